// File: rtl/muldiv_32_pkg.sv
// Shared opcode, state and iteration-count definitions for the multiply/divide unit.
package muldiv_32_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_e;

  localparam int unsigned MD_ITERS     = 32;
  localparam logic [4:0]  MD_LAST_ITER = 5'(MD_ITERS - 1);

  function automatic logic op_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_32_if.sv
// Operand/command and HI/LO result bundle between execute-stage control and muldiv_32.
interface muldiv_32_if #(
  parameter int unsigned XLEN = 32
) ();
  import muldiv_32_pkg::*;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  md_op_e          op;
  logic            start;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            div_by_zero;

  modport master (
    output a, b, op, start, mthi, mtlo,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  a, b, op, start, mthi, mtlo,
    output hi, lo, busy, done, div_by_zero
  );

endinterface

// File: rtl/muldiv_32_negate.sv
// 32-bit complement-and-increment; carry_in=1 gives a plain two's-complement negate,
// carry_in from a lower half chains two instances into a wider negate.
module negate_32 (
  input  logic [31:0] value,
  input  logic        carry_in,
  output logic [31:0] result
);

  assign result = ~value + {31'd0, carry_in};

endmodule

// File: rtl/muldiv_32.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (mult, multu, div, divu, mthi, mtlo).
module muldiv_32
  import muldiv_32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_32_if.slave  bus
);

  md_state_e       state_q, state_d;
  logic [4:0]      iter_q;
  md_op_e          op_q;
  logic            sign_a_q, sign_q_q, b_zero_q;
  logic [XLEN-1:0] a_raw_q, opa_q, opb_q;
  logic [XLEN-1:0] acc_hi_q, acc_lo_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            done_q, dbz_q;

  logic            busy, load, step, fix, move;
  logic            signed_op;
  logic [XLEN-1:0] neg_a, neg_b, abs_a, abs_b;
  logic [XLEN-1:0] neg_lo, neg_hi;
  logic            hi_carry;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic            take;
  logic [XLEN-1:0] sub_diff;
  logic [XLEN-1:0] fix_hi, fix_lo;

  // Operand magnitudes for signed ops
  assign signed_op = op_is_signed(bus.op);

  negate_32 u_neg_a (.value(bus.a), .carry_in(1'b1), .result(neg_a));
  negate_32 u_neg_b (.value(bus.b), .carry_in(1'b1), .result(neg_b));

  assign abs_a = (signed_op && bus.a[XLEN-1]) ? neg_a : bus.a;
  assign abs_b = (signed_op && bus.b[XLEN-1]) ? neg_b : bus.b;

  // Result sign fix: the low instance negates LO/quotient; the high instance
  // negates HI/remainder, taking the borrow from the low half for a 64-bit product
  assign hi_carry = op_is_div(op_q) ? 1'b1 : (acc_lo_q == '0);

  negate_32 u_neg_lo (.value(acc_lo_q), .carry_in(1'b1),     .result(neg_lo));
  negate_32 u_neg_hi (.value(acc_hi_q), .carry_in(hi_carry), .result(neg_hi));

  // Shift-add step (LSB first) and restoring trial subtract (MSB first)
  assign add_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);
  assign shifted  = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign take     = (shifted >= {1'b0, opb_q});
  assign sub_diff = shifted[XLEN-1:0] - opb_q;

  // Final HI/LO values written in FIX
  always_comb begin
    fix_hi = acc_hi_q;
    fix_lo = acc_lo_q;
    if (op_is_div(op_q)) begin
      if (b_zero_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = sign_a_q ? neg_hi : acc_hi_q;
        fix_lo = sign_q_q ? neg_lo : acc_lo_q;
      end
    end else if (sign_q_q) begin
      fix_hi = neg_hi;
      fix_lo = neg_lo;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (bus.start) state_d = MD_RUN;
      MD_RUN:  if (iter_q == MD_LAST_ITER) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // State decode into datapath strobes and busy
  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    fix  = 1'b0;
    move = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        load = bus.start;
        move = !bus.start;
      end
      MD_RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      MD_FIX: begin
        busy = 1'b1;
        fix  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q   <= '0;
      op_q     <= MD_MULT;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_raw_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= fix;
      dbz_q  <= fix && op_is_div(op_q) && b_zero_q;
      if (load) begin
        iter_q   <= '0;
        op_q     <= bus.op;
        sign_a_q <= signed_op && bus.a[XLEN-1];
        sign_q_q <= signed_op && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
        b_zero_q <= (bus.b == '0);
        a_raw_q  <= bus.a;
        opa_q    <= abs_a;
        opb_q    <= abs_b;
        acc_hi_q <= '0;
        acc_lo_q <= op_is_div(bus.op) ? abs_a : abs_b;
      end
      if (step) begin
        iter_q <= iter_q + 5'd1;
        if (op_is_div(op_q)) begin
          acc_hi_q <= take ? sub_diff : shifted[XLEN-1:0];
          acc_lo_q <= {acc_lo_q[XLEN-2:0], take};
        end else begin
          acc_hi_q <= add_sum[XLEN:1];
          acc_lo_q <= {add_sum[0], acc_lo_q[XLEN-1:1]};
        end
      end
      if (fix) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
      if (move) begin
        if (bus.mthi) hi_q <= bus.a;
        if (bus.mtlo) lo_q <= bus.a;
      end
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_32.sv
// Randomized and directed scoreboard bench for muldiv_32.
module tb_muldiv_32;
  import muldiv_32_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  muldiv_32_if #(.XLEN(32)) bus ();

  muldiv_32 #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // MIPS semantics computed with wide integer arithmetic
  function automatic exp_t ref_model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic signed [63:0] sa, sb_, sp, sq, sr;
    logic [63:0] up;
    r.dbz = 1'b0;
    sa = $signed(a);
    sb_ = $signed(b);
    case (op)
      MD_MULT: begin
        sp = sa * sb_;
        r.hi = sp[63:32];
        r.lo = sp[31:0];
      end
      MD_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = 32'hFFFF_FFFF;
          r.dbz = 1'b1;
        end else if (op == MD_DIV) begin
          sq = sa / sb_;
          sr = sa % sb_;
          r.hi = sr[31:0];
          r.lo = sq[31:0];
        end else begin
          r.hi = a % b;
          r.lo = a / b;
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: pop one expectation per done pulse
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
      end
    end else begin
      check("dbz_outside_done", {31'd0, bus.div_by_zero}, 32'd0);
    end
  end

  // Issue one op and walk it through its 33-cycle latency
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit with_move);
    logic [31:0] hi_before;
    hi_before = bus.hi;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    bus.mthi  = with_move;
    sb.push_back(ref_model(op, a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    if (with_move) check("start_beats_mthi", bus.hi, hi_before);
    for (int e = 1; e <= 33; e++) begin
      check("busy_run", {31'd0, bus.busy}, 32'd1);
      check("done_early", {31'd0, bus.done}, 32'd0);
      if (disturb && e == 5) begin
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.a     = ~a;
        bus.b     = b + 32'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      if (disturb && e == 5) check("hi_hold_busy", bus.hi, hi_before);
    end
    check("done_at_33", {31'd0, bus.done}, 32'd1);
    check("busy_clear", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    md_op_e op;
    logic [31:0] a, b;
    int unsigned sel;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.a = '0; bus.b = '0; bus.op = MD_MULT;
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);

    // Directed cases
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    run_op(MD_DIVU,  32'd7,         32'd12,        1'b0, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(MD_DIVU,  32'd7,         32'd0,         1'b0, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FF00, 32'd0,         1'b0, 1'b0);

    // Moves in IDLE
    bus.a = 32'h1234_5678; bus.mthi = 1'b1;
    @(posedge clk); #1 bus.mthi = 1'b0;
    check("mthi", bus.hi, 32'h1234_5678);
    bus.a = 32'h9ABC_DEF0; bus.mtlo = 1'b1;
    @(posedge clk); #1 bus.mtlo = 1'b0;
    check("mtlo", bus.lo, 32'h9ABC_DEF0);
    check("mtlo_keeps_hi", bus.hi, 32'h1234_5678);
    bus.a = 32'hCAFE_F00D; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(posedge clk); #1 begin bus.mthi = 1'b0; bus.mtlo = 1'b0; end
    check("mthi_both", bus.hi, 32'hCAFE_F00D);
    check("mtlo_both", bus.lo, 32'hCAFE_F00D);

    // Start with a move, and a busy-time start+mthi that must be dropped
    run_op(MD_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b1, 1'b1);

    // Reset mid-multiply
    bus.op = MD_MULT; bus.a = 32'd5; bus.b = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    run_op(MD_MULT, 32'd6, 32'd7, 1'b0, 1'b0);

    // Randomized back-to-back ops
    for (int n = 0; n < 60; n++) begin
      op  = md_op_e'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      run_op(op, a, b, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
